playback_l15_sequencer: RTL and testbench

PLAYBACK_L15_SEQUENCER -- requirements
Module: playback_l15_sequencer

---
 rtl/playback_l15_sequencer.sv | 109 ++++++++++
 tb/tb_playback_l15_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_l15_sequencer.sv
// Replays stored L1.5 vectors {clk_flag, stimulus, expected}, 3 cycles per vector (FETCH/APPLY/CHECK), fixed 1-cycle memory, no backpressure.
// Optional PLAYBACK_STOP_ON_MISMATCH_EN: first compare mismatch parks the sequencer in FAIL.
module playback_l15_sequencer #(
    parameter int IN_W   = 357,
    parameter int OUT_W  = 371,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W:0]           vec_count,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [IN_W+OUT_W:0]       mem_rd_data,
    output logic [IN_W-1:0]           dut_in_vec,
    output logic                      dut_clk_en,
    input  logic [OUT_W-1:0]          dut_out_vec,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               mismatch_cnt,
    output logic [ADDR_W-1:0]         first_fail_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

`ifdef PLAYBACK_STOP_ON_MISMATCH_EN
    localparam bit STOP_ON_MISMATCH = 1'b1;
`else
    localparam bit STOP_ON_MISMATCH = 1'b0;
`endif

    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [ADDR_W:0]  idx;
    logic [ADDR_W:0]  count;
    logic [OUT_W-1:0] exp_vec;
    logic             clk_flag;
    logic             mismatch;
    logic             last_vec;

    // Pre-clock samples (clk_flag=0) are never compared.
    assign mismatch    = clk_flag && (dut_out_vec != exp_vec);
    assign last_vec    = (idx + IDX_ONE) == count;
    assign mem_rd_en   = (state == S_FETCH);
    assign mem_rd_addr = idx[ADDR_W-1:0];
    assign busy        = (state == S_FETCH) || (state == S_APPLY) || (state == S_CHECK);
    assign done        = (state == S_DONE) || (state == S_FAIL);
    assign pass        = (state == S_DONE) && (mismatch_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            idx            <= '0;
            count          <= '0;
            exp_vec        <= '0;
            clk_flag       <= 1'b0;
            dut_in_vec     <= '0;
            dut_clk_en     <= 1'b0;
            mismatch_cnt   <= 16'd0;
            first_fail_idx <= '0;
        end else begin
            dut_clk_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        idx            <= '0;
                        mismatch_cnt   <= 16'd0;
                        first_fail_idx <= '0;
                        count          <= vec_count;
                        state          <= (vec_count == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state <= S_APPLY;
                S_APPLY: begin
                    dut_in_vec <= mem_rd_data[IN_W+OUT_W-1:OUT_W];
                    exp_vec    <= mem_rd_data[OUT_W-1:0];
                    clk_flag   <= mem_rd_data[IN_W+OUT_W];
                    dut_clk_en <= mem_rd_data[IN_W+OUT_W];
                    state      <= S_CHECK;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (mismatch_cnt != 16'hFFFF)
                            mismatch_cnt <= mismatch_cnt + 16'd1;
                        if (mismatch_cnt == 16'd0)
                            first_fail_idx <= idx[ADDR_W-1:0];
                    end
                    if (STOP_ON_MISMATCH && mismatch) begin
                        state <= S_FAIL;
                    end else if (last_vec) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_playback_l15_sequencer.sv
// Scoreboard bench: stimulus pushes expected reads, clock pulses and run results; a negedge monitor pops and compares.
module tb_playback_l15_sequencer;

    localparam int IW = 16;
    localparam int OW = 16;
    localparam int AW = 3;
    localparam int DW = 1 + IW + OW;
    localparam logic [IW-1:0] XFORM = 16'h5A5A;

    logic           clk;
    logic           rst;
    logic           start;
    logic [AW:0]    vec_count;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    logic [DW-1:0]  mem_rd_data;
    logic [IW-1:0]  dut_in_vec;
    logic           dut_clk_en;
    logic [OW-1:0]  dut_out_vec;
    logic           busy;
    logic           done;
    logic           pass;
    logic [15:0]    mismatch_cnt;
    logic [AW-1:0]  first_fail_idx;

    playback_l15_sequencer #(.IN_W(IW), .OUT_W(OW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .dut_in_vec(dut_in_vec), .dut_clk_en(dut_clk_en), .dut_out_vec(dut_out_vec),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector memory with a fixed 1-cycle read, and a trivial combinational L1.5 stand-in.
    logic [DW-1:0] vmem [0:(1<<AW)-1];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= vmem[mem_rd_addr];
    assign dut_out_vec = dut_in_vec ^ XFORM;

    typedef struct {
        int            lat;
        int            mm;
        int            ffi;
        bit            pas;
        logic [IW-1:0] last_in;
    } res_t;

    logic [AW-1:0] rd_q[$];
    logic [IW-1:0] clk_q[$];
    res_t          res_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    bit armed = 1'b0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                armed = 1'b0;
            end else begin
                if (mem_rd_en) begin
                    if (rd_q.size() == 0) check("unexpected_rd", 64'(mem_rd_addr), 64'hFFFF);
                    else check("rd_addr", 64'(mem_rd_addr), 64'(rd_q.pop_front()));
                end
                if (dut_clk_en) begin
                    if (clk_q.size() == 0) check("unexpected_clk_en", 64'(dut_in_vec), 64'hFFFF_FFFF);
                    else check("clk_en_in_vec", 64'(dut_in_vec), 64'(clk_q.pop_front()));
                end
                if (armed && done) begin
                    armed = 1'b0;
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        r = res_q.pop_front();
                        check("done_latency", 64'(cyc - t0 - 1), 64'(r.lat));
                        check("mismatch_cnt", 64'(mismatch_cnt), 64'(r.mm));
                        check("first_fail_idx", 64'(first_fail_idx), 64'(r.ffi));
                        check("pass", 64'(pass), 64'(r.pas));
                        check("held_in_vec", 64'(dut_in_vec), 64'(r.last_in));
                        check("busy_at_done", 64'(busy), 64'd0);
                    end
                end else if (!armed && start && !busy) begin
                    armed = 1'b1;
                    t0 = cyc;
                end
            end
        end
    end

    function automatic void setv(int a, bit flag, logic [IW-1:0] in, bit match);
        logic [OW-1:0] e;
        e = (in ^ XFORM) ^ (match ? 16'h0000 : 16'h0100);
        vmem[a] = {flag, in, e};
    endfunction

    // Load a vector and push the responses it should provoke.
    task automatic vec(int a, bit flag, logic [IW-1:0] in, bit match, bit expect_seen);
        setv(a, flag, in, match);
        if (expect_seen) begin
            rd_q.push_back(AW'(a));
            if (flag) clk_q.push_back(in);
        end
    endtask

    task automatic expect_res(int lat, int mm, int ffi, bit pas, logic [IW-1:0] last_in);
        res_t r;
        r.lat = lat; r.mm = mm; r.ffi = ffi; r.pas = pas; r.last_in = last_in;
        res_q.push_back(r);
    endtask

    task automatic run(int n, int poke);
        @(posedge clk); #1;
        vec_count = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1 start = 1'b1; vec_count = (AW+1)'(1);
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 3*n + 20 && res_q.size() != 0; i++) @(posedge clk);
        if (res_q.size() != 0) begin
            check("run_timeout", 64'(res_q.size()), 64'd0);
            res_q.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset();
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_rd_addr", 64'(mem_rd_addr), 64'd0);
        check("rst_dut_in_vec", 64'(dut_in_vec), 64'd0);
        check("rst_dut_clk_en", 64'(dut_clk_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
        check("rst_first_fail_idx", 64'(first_fail_idx), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; vec_count = '0;
        repeat (3) @(posedge clk);
        #1 check_reset();
        rst = 1'b0;

        // 4 matching clocked vectors
        vec(0, 1, 16'h1111, 1, 1);
        vec(1, 1, 16'h2222, 1, 1);
        vec(2, 1, 16'h3333, 1, 1);
        vec(3, 1, 16'h4444, 1, 1);
        expect_res(12, 0, 0, 1, 16'h4444);
        run(4, 0);

        // vector 1 mismatches
`ifdef PLAYBACK_STOP_ON_MISMATCH_EN
        vec(0, 1, 16'h0A0A, 1, 1);
        vec(1, 1, 16'h0B0B, 0, 1);
        vec(2, 1, 16'h0C0C, 1, 0);
        expect_res(6, 1, 1, 0, 16'h0B0B);
`else
        vec(0, 1, 16'h0A0A, 1, 1);
        vec(1, 1, 16'h0B0B, 0, 1);
        vec(2, 1, 16'h0C0C, 1, 1);
        expect_res(9, 1, 1, 0, 16'h0C0C);
`endif
        run(3, 0);
        repeat (6) @(posedge clk);

        // empty run: counters cleared, stimulus held
`ifdef PLAYBACK_STOP_ON_MISMATCH_EN
        expect_res(0, 0, 0, 1, 16'h0B0B);
`else
        expect_res(0, 0, 0, 1, 16'h0C0C);
`endif
        run(0, 0);

        // pre-clock samples with deliberate mismatches are not compared
        vec(0, 0, 16'h1234, 0, 1);
        vec(1, 0, 16'h2345, 0, 1);
        vec(2, 1, 16'h3456, 1, 1);
        expect_res(9, 0, 0, 1, 16'h3456);
        run(3, 0);

        // full address range, two mismatches, start poked mid-run
`ifdef PLAYBACK_STOP_ON_MISMATCH_EN
        vec(0, 1, 16'hA000, 1, 1);
        vec(1, 0, 16'hA001, 0, 1);
        vec(2, 1, 16'hA002, 0, 1);
        vec(3, 0, 16'hA003, 0, 0);
        vec(4, 1, 16'hA004, 1, 0);
        vec(5, 1, 16'hA005, 0, 0);
        vec(6, 1, 16'hA006, 1, 0);
        vec(7, 1, 16'hA007, 1, 0);
        expect_res(9, 1, 2, 0, 16'hA002);
`else
        vec(0, 1, 16'hA000, 1, 1);
        vec(1, 0, 16'hA001, 0, 1);
        vec(2, 1, 16'hA002, 0, 1);
        vec(3, 0, 16'hA003, 0, 1);
        vec(4, 1, 16'hA004, 1, 1);
        vec(5, 1, 16'hA005, 0, 1);
        vec(6, 1, 16'hA006, 1, 1);
        vec(7, 1, 16'hA007, 1, 1);
        expect_res(24, 2, 2, 0, 16'hA007);
`endif
        run(8, 4);

        // reset while in APPLY of a 5-vector run
        for (int i = 0; i < 5; i++) setv(i, 1, IW'(16'h7000 + i), 1);
        rd_q.push_back(AW'(0));
        @(posedge clk); #1;
        vec_count = (AW+1)'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset();
        rst = 1'b0;

        // recovery from IDLE
        vec(0, 1, 16'h7777, 1, 1);
        expect_res(3, 0, 0, 1, 16'h7777);
        run(1, 0);

        check("leftover_rd", 64'(rd_q.size()), 64'd0);
        check("leftover_clk_en", 64'(clk_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
